// File: rtl/fetch_inst_queue_pkg.sv
// rtl/fetch_inst_queue_pkg.sv - shared constants and types for the fetch instruction queue
package fetch_inst_queue_pkg;

    localparam int DEPTH_WIDTH = 3;
    localparam int INST_WIDTH  = 32;
    localparam int PC_WIDTH    = 32;
    localparam int ENTRIES     = 1 << DEPTH_WIDTH;
    localparam int ENTRY_WIDTH = INST_WIDTH + PC_WIDTH;

    // One queued instruction; packed so {inst, pc} is the storage word layout.
    typedef struct packed {
        logic [INST_WIDTH-1:0] inst;
        logic [PC_WIDTH-1:0]   pc;
    } iq_entry_t;

    typedef logic [DEPTH_WIDTH-1:0] iq_ptr_t;
    typedef logic [DEPTH_WIDTH:0]   iq_count_t;

    // Split a storage word back into its fields.
    function automatic iq_entry_t iq_unpack(input logic [ENTRY_WIDTH-1:0] word);
        iq_entry_t e;
        e = iq_entry_t'(word);
        return e;
    endfunction

endpackage

// File: rtl/fetch_inst_queue_ram.sv
// rtl/fetch_inst_queue_ram.sv - dual-write, dual-read register array for queued instructions
module fetch_inst_queue_ram
    import fetch_inst_queue_pkg::*;
#(
    parameter int addr_width = DEPTH_WIDTH,
    parameter int data_width = ENTRY_WIDTH
) (
    input  logic                  clk,
    input  logic                  we0,
    input  logic [addr_width-1:0] waddr0,
    input  logic [data_width-1:0] wdata0,
    input  logic                  we1,
    input  logic [addr_width-1:0] waddr1,
    input  logic [data_width-1:0] wdata1,
    input  logic [addr_width-1:0] raddr0,
    output logic [data_width-1:0] rdata0,
    input  logic [addr_width-1:0] raddr1,
    output logic [data_width-1:0] rdata1
);

    logic [data_width-1:0] mem [1 << addr_width];

    // Write up to two entries per cycle; the addresses are always distinct when both fire.
    always_ff @(posedge clk) begin
        if (we0) begin
            mem[waddr0] <= wdata0;
        end
        if (we1) begin
            mem[waddr1] <= wdata1;
        end
    end

    assign rdata0 = mem[raddr0];
    assign rdata1 = mem[raddr1];

endmodule

// File: rtl/fetch_inst_queue.sv
// rtl/fetch_inst_queue.sv - instruction queue between the icache and decode
module fetch_inst_queue
    import fetch_inst_queue_pkg::*;
#(
    parameter int depth_width = DEPTH_WIDTH,
    parameter int inst_width  = INST_WIDTH
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [2*inst_width-1:0] in_inst,
    input  logic [PC_WIDTH-1:0]    in_pc,
    input  logic                   in_flag,
    output logic                   out_valid0,
    output logic [inst_width-1:0]  out_inst0,
    output logic [PC_WIDTH-1:0]    out_pc0,
    output logic                   out_valid1,
    output logic [inst_width-1:0]  out_inst1,
    output logic [PC_WIDTH-1:0]    out_pc1,
    input  logic                   dec_accept,
    output logic [depth_width:0]   count
);

    localparam int entries     = 1 << depth_width;
    localparam int entry_width = inst_width + PC_WIDTH;

    // Accept only when two slots are free, so a two-instruction packet always fits.
    localparam logic [depth_width:0] ready_limit = (depth_width + 1)'(entries - 2);
    localparam logic [depth_width:0] count_one   = (depth_width + 1)'(1);

    logic [depth_width-1:0] head_q;
    logic [depth_width-1:0] tail_q;
    logic [depth_width:0]   count_q;

    logic [depth_width-1:0] head_d;
    logic [depth_width-1:0] tail_d;
    logic [depth_width:0]   count_d;

    logic                   push;
    logic                   pop;
    logic [1:0]             wnum;
    logic [1:0]             rnum;

    logic [entry_width-1:0] wdata0;
    logic [entry_width-1:0] wdata1;
    logic [entry_width-1:0] rdata0;
    logic [entry_width-1:0] rdata1;
    logic [depth_width-1:0] tail_plus1;
    logic [depth_width-1:0] head_plus1;

    // Status depends only on registered count, never on this cycle's dec_accept.
    assign in_ready   = (count_q <= ready_limit);
    assign out_valid0 = (count_q != '0);
    assign out_valid1 = (count_q > count_one);
    assign count      = count_q;

    assign push = in_valid & in_ready;
    assign pop  = dec_accept & out_valid0;
    assign wnum = push ? (in_flag ? 2'd2 : 2'd1) : 2'd0;
    assign rnum = pop ? (out_valid1 ? 2'd2 : 2'd1) : 2'd0;

    assign tail_plus1 = tail_q + depth_width'(1);
    assign head_plus1 = head_q + depth_width'(1);

    assign wdata0 = {in_inst[inst_width-1:0], in_pc};
    assign wdata1 = {in_inst[2*inst_width-1:inst_width], in_pc + PC_WIDTH'(4)};

    fetch_inst_queue_ram #(
        .addr_width (depth_width),
        .data_width (entry_width)
    ) u_ram (
        .clk    (clk),
        .we0    (push & ~flush),
        .waddr0 (tail_q),
        .wdata0 (wdata0),
        .we1    (push & in_flag & ~flush),
        .waddr1 (tail_plus1),
        .wdata1 (wdata1),
        .raddr0 (head_q),
        .rdata0 (rdata0),
        .raddr1 (head_plus1),
        .rdata1 (rdata1)
    );

    // Next pointer/count state; flush overrides any same-cycle push or pop.
    always_comb begin
        head_d  = head_q + depth_width'(rnum);
        tail_d  = tail_q + depth_width'(wnum);
        count_d = count_q + (depth_width + 1)'(wnum) - (depth_width + 1)'(rnum);
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Present the two oldest entries, zeroed when not valid.
    always_comb begin
        out_inst0 = '0;
        out_pc0   = '0;
        out_inst1 = '0;
        out_pc1   = '0;
        if (out_valid0) begin
            out_inst0 = rdata0[entry_width-1:PC_WIDTH];
            out_pc0   = rdata0[PC_WIDTH-1:0];
        end
        if (out_valid1) begin
            out_inst1 = rdata1[entry_width-1:PC_WIDTH];
            out_pc1   = rdata1[PC_WIDTH-1:0];
        end
    end

endmodule

// File: doc/fetch_inst_queue.md
Name: fetch_inst_queue

Overview:
- Instruction queue directly downstream of the L1 instruction cache.
- Accepts one fetch packet per cycle: 1 or 2 instructions plus the packet PC.
- Stores instructions in a circular buffer and presents up to two oldest instructions, in program order, to decode.
- Decouples icache fetch latency from decode stalls; cleared on pipeline flush (branch/exception redirect).

Parameters:
- depth_width, 3, log2 of entry count (8 entries, each one instruction + PC)
- inst_width, 32, instruction width in bits

Ports:
- clk  input  1  clock; all state updates on rising edge
- rstn  input  1  reset, asynchronous, active-low
- flush  input  1  discard all queued entries this cycle
- in_valid  input  1  fetch packet present
- in_ready  output  1  queue can accept a packet (free slots >= 2)
- in_inst  input  64  [31:0] instruction at in_pc; [63:32] instruction at in_pc+4
- in_pc  input  32  PC of in_inst[31:0]
- in_flag  input  1  1: [63:32] valid; 0: [63:32] ignored
- out_valid0  output  1  head entry valid
- out_inst0  output  32  head instruction
- out_pc0  output  32  head PC
- out_valid1  output  1  second entry valid (only when out_valid0=1)
- out_inst1  output  32  second instruction
- out_pc1  output  32  second PC
- dec_accept  input  1  decode consumes every currently valid output entry (1 or 2) this cycle
- count  output  depth_width+1  number of occupied entries

Behaviour:
- Storage: 2^depth_width entries of {inst, pc}.
  - head and tail pointers are depth_width bits and wrap modulo 2^depth_width.
  - count is depth_width+1 bits, range 0..2^depth_width.
- Reset (rstn=0, asynchronous): head=0, tail=0, count=0.
  - Outputs during and after reset: out_valid0=0, out_valid1=0, in_ready=1.
  - out_inst*/out_pc* read 0.
  - Storage contents need not be reset.
- Write number: push = in_valid & in_ready; wnum = push ? (in_flag ? 2 : 1) : 0.
  - Entry tail gets {in_inst[31:0], in_pc}.
  - If wnum=2, entry tail+1 (wrapped) gets {in_inst[63:32], in_pc+4}.
  - tail advances by wnum.
- Read number: pop = dec_accept & out_valid0; rnum = pop ? (out_valid1 ? 2 : 1) : 0.
  - head advances by rnum.
- Count: next count = count + wnum - rnum. Simultaneous push and pop are both honoured in the same cycle.
- Output validity:
  - out_valid0 = (count >= 1).
  - out_valid1 = (count >= 2).
  - out_*0 reads entry head; out_*1 reads entry head+1 (wrapped).
  - out_inst/out_pc are forced to 0 when the corresponding valid is 0.
- Timing: outputs are combinational from registered state; no bypass.
  - An instruction pushed in cycle N is visible at the outputs in cycle N+1 at the earliest.
- in_ready = (2^depth_width - count >= 2).
  - Computed from current count only, not from this cycle's pop (no combinational path from dec_accept to in_ready).
  - Full at 7 or 8 entries.
- Flush has highest priority:
  - next head=0, tail=0, count=0.
  - Same-cycle push and pop are ignored.
  - in_ready stays as computed from the current count, but any accepted packet is discarded.
  - Outputs invalid in the next cycle.
- Behaviour on invalid inputs: in_valid while in_ready=0 causes no state change. dec_accept while out_valid0=0 causes no state change.
- Wrap-around: a two-instruction push with tail=7 writes entries 7 and 0. A two-instruction pop with head=7 reads entries 7 and 0.
- PC arithmetic: in_pc+4 is a 32-bit modulo add; no alignment check.
- No state machine beyond pointer/count state; all control is single-cycle.

Decomposition:
- Shared package: depth_width, inst_width, entry count constant (1<<depth_width), entry struct/packing width (inst_width+32).
- Natural sub-module: fetch_inst_queue_ram.
  - Register-array storage with 2 write ports (addresses tail, tail+1) and 2 combinational read ports (head, head+1).
  - No reset on the array.
- Pointer/count/ready logic lives in the top module.

Test Plan:
- Reset, then push in_pc=0x1C000000, in_inst=0x22222222_11111111, in_flag=1 -> next cycle count=2, out_inst0=0x11111111 (pc 0x1C000000), out_inst1=0x22222222 (pc 0x1C000004).
- Single-instruction push (in_flag=0, in_inst[63:32]=0x1234ABCD, pc=0x1C000008) into an empty queue -> out_valid0=1, out_valid1=0, out_inst1=0. Assert dec_accept -> count returns to 0.
- Fill with 4 two-instruction pushes, dec_accept=0 -> count=8, in_ready=0. A further in_valid is ignored.
  - Then dec_accept for one cycle -> count=6, in_ready=1 in the following cycle.
- Wrap: preload so head=tail=7. Push 2 with pop 0, then pop 2 -> instructions read back in order via entries 7 and 0, count ends 0.
- Simultaneous push(2) and pop(2) with count=4 -> count stays 4, head and tail both advance by 2.
- Flush with in_valid=1 and dec_accept=1 at count=5 -> next cycle count=0, out_valid0=0, in_ready=1.
- Assert rstn=0 mid-stream -> outputs invalid immediately, without waiting for a clock edge.
